mux2_share_arbiter: RTL

- Round-robin arbiter and sequencer for the shared 8-bit two-input multiplexer (I0, I1, S, Z).
- Grants the mux to one of two requesters at a time and drives the mux select S.
- Captures mux output Z into a registered valid/ready output stage, with bounded burst length per grant.
- Sits between two producer blocks and one downstream consumer.

---
 rtl/mux2_share_arbiter_if.sv | 29 ++
 rtl/mux2_share_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mux2_share_arbiter_if.sv
// Bus between the shared-mux arbiter, its two producers, the mux and the consumer.
// The slave modport is the arbiter's view; the master modport is everything around it.
interface mux2_share_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic             last0;
    logic             last1;
    logic             gnt0;
    logic             gnt1;
    logic             ack0;
    logic             ack1;
    logic             sel;
    logic [WIDTH-1:0] mux_z;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  req0, req1, last0, last1, mux_z, out_ready,
        output gnt0, gnt1, ack0, ack1, sel, out_data, out_valid
    );

    modport master (
        output req0, req1, last0, last1, mux_z, out_ready,
        input  gnt0, gnt1, ack0, ack1, sel, out_data, out_valid
    );
endinterface

// File: rtl/mux2_share_arbiter.sv
// Round-robin owner of a shared 2:1 mux: grants one requester at a time, drives
// the mux select and captures Z into a registered valid/ready output stage.
module mux2_share_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    mux2_share_arbiter_if.slave bus,
    output logic [1:0]       state_dbg,
    output logic [CNT_W-1:0] beat_cnt_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic             last_served;
    logic             sel_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;

    logic             slot_free;
    logic             ack0;
    logic             ack1;
    logic             at_max;
    logic             rel0;
    logic             rel1;
    logic [CNT_W-1:0] beat_nxt;

    // Handshake: a beat moves from the granted requester into the output register
    // when ackx (gnt & req & slot_free) is high; out_data transfers to the consumer
    // on any edge where out_valid & out_ready. Both may happen on the same edge.
    always_comb begin
        slot_free = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        beat_nxt  = '0;
        at_max    = 1'b0;
        rel0      = 1'b0;
        rel1      = 1'b0;
        slot_free = !out_valid_q || bus.out_ready;
        ack0      = (state == G0) && bus.req0 && slot_free;
        ack1      = (state == G1) && bus.req1 && slot_free;
        beat_nxt  = beat_cnt + CNT_W'(1);
        at_max    = (beat_nxt == CNT_W'(MAX_BURST));
        // A withdrawn request releases without a beat; last and max-count coincide into one release.
        rel0      = !bus.req0 || (ack0 && (bus.last0 || at_max));
        rel1      = !bus.req1 || (ack1 && (bus.last1 || at_max));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            last_served <= 1'b1;
            sel_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (ack0 || ack1) begin
                out_data_q  <= bus.mux_z;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.req0 && (!bus.req1 || last_served)) begin
                        state <= G0;
                        sel_q <= 1'b0;
                    end else if (bus.req1) begin
                        state <= G1;
                        sel_q <= 1'b1;
                    end
                end
                G0: begin
                    if (ack0) beat_cnt <= beat_nxt;
                    if (rel0) begin
                        last_served <= 1'b0;
                        beat_cnt    <= '0;
                        if (bus.req1) begin
                            state <= G1;
                            sel_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                G1: begin
                    if (ack1) beat_cnt <= beat_nxt;
                    if (rel1) begin
                        last_served <= 1'b1;
                        beat_cnt    <= '0;
                        if (bus.req0) begin
                            state <= G0;
                            sel_q <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0      = (state == G0);
    assign bus.gnt1      = (state == G1);
    assign bus.ack0      = ack0;
    assign bus.ack1      = ack1;
    assign bus.sel       = sel_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign state_dbg     = state;
    assign beat_cnt_dbg  = beat_cnt;
endmodule
